// File: rtl/sync_debouncer.sv
// sync_debouncer: stable-count debouncer for an already-synchronized level.
// A candidate level must be seen on DEBOUNCE_CYCLES consecutive enabled
// samples before it is accepted. Produces a registered level plus one-cycle
// rise/fall strobes. Define SYNC_DEBOUNCER_EVT_CNT_EN to add a saturating
// count of accepted rising events on port evt_count.
module sync_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int RESET_LEVEL     = 0,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sync,
  input  logic             enable,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             busy
`ifdef SYNC_DEBOUNCER_EVT_CNT_EN
  ,
  output logic [EVT_W-1:0] evt_count
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic             RESET_BIT   = (RESET_LEVEL != 0);
  localparam state_t           RESET_STATE = RESET_BIT ? STABLE_HI : STABLE_LO;
  // Count value at which the next matching sample is the accepting one.
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifndef SYNTHESIS
  // Reject configurations whose acceptance count cannot fit the counter.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 || EVT_W < 1) begin : g_cfg_error
    $fatal(1, "sync_debouncer: DEBOUNCE_CYCLES must be in 2..2^CNT_W-1 and EVT_W >= 1");
  end
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             fall_next;
  logic             busy_next;

  // Next-state, counter and strobe decisions; everything holds when disabled.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (enable) begin
      unique case (state_reg)
        STABLE_LO: begin
          if (in_sync) begin
            state_next = WAIT_HI;
            cnt_next   = CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!in_sync) begin
            // Glitch: drop back without touching the level.
            state_next = STABLE_LO;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = STABLE_HI;
            cnt_next   = '0;
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!in_sync) begin
            state_next = WAIT_LO;
            cnt_next   = CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (in_sync) begin
            state_next = STABLE_HI;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = STABLE_LO;
            cnt_next   = '0;
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = RESET_STATE;
          cnt_next   = '0;
        end
      endcase
    end
    busy_next = (state_next == WAIT_HI) || (state_next == WAIT_LO);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      level     <= RESET_BIT;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level     <= level_next;
      rise      <= rise_next;
      fall      <= fall_next;
      busy      <= busy_next;
    end
  end

`ifdef SYNC_DEBOUNCER_EVT_CNT_EN
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  // Saturating count of accepted rising events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_count <= '0;
    end else if (rise_next && (evt_count != EVT_MAX)) begin
      evt_count <= evt_count + EVT_W'(1);
    end
  end
`endif

endmodule
